// File: rtl/intr_vec_ctrl_if.sv
// Register-strobe, cause-input and per-vector request/ack bundle for intr_vec_ctrl.
// master = software/bus side plus message generator; slave = the controller.
interface intr_vec_ctrl_if #(
  parameter int NUM_SRC = 32,
  parameter int NUM_VEC = 4,
  parameter int ITR_W   = 16
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int VEC_W = $clog2(NUM_VEC);

  logic [NUM_SRC-1:0] src_req_i;
  logic [NUM_SRC-1:0] reg_wdata_i;
  logic               icr_get_i;
  logic               icr_clr_i;
  logic               ics_set_i;
  logic               ims_set_i;
  logic               imc_set_i;
  logic               itr_set_i;
  logic [VEC_W-1:0]   itr_idx_i;
  logic [ITR_W-1:0]   itr_val_i;
  logic               ivar_set_i;
  logic [SRC_W-1:0]   ivar_src_i;
  logic [VEC_W-1:0]   ivar_vec_i;
  logic [NUM_SRC-1:0] icr_o;
  logic [NUM_SRC-1:0] ims_o;
  logic [NUM_VEC-1:0] vec_req_o;
  logic [NUM_VEC-1:0] vec_ack_i;

  modport master (
    output src_req_i, reg_wdata_i, icr_get_i, icr_clr_i, ics_set_i,
           ims_set_i, imc_set_i, itr_set_i, itr_idx_i, itr_val_i,
           ivar_set_i, ivar_src_i, ivar_vec_i, vec_ack_i,
    input  icr_o, ims_o, vec_req_o
  );

  modport slave (
    input  src_req_i, reg_wdata_i, icr_get_i, icr_clr_i, ics_set_i,
           ims_set_i, imc_set_i, itr_set_i, itr_idx_i, itr_val_i,
           ivar_set_i, ivar_src_i, ivar_vec_i, vec_ack_i,
    output icr_o, ims_o, vec_req_o
  );
endinterface

// File: rtl/intr_vec_ctrl.sv
// Multi-vector interrupt controller: sticky causes, mask, cause->vector map, per-vector ITR holdoff.
// Define INTR_AUTOCLR_EN to clear a vector's mapped causes when its message is acknowledged.
module intr_vec_ctrl #(
  parameter int NUM_SRC       = 32,
  parameter int NUM_VEC       = 4,
  parameter int ITR_W         = 16,
  parameter int CLK_PERIOD_NS = 8,
  parameter int TICK_NS       = 256
) (
  input logic            clk_i,
  input logic            rst_ni,
  intr_vec_ctrl_if.slave bus
);
  localparam int SRC_W       = $clog2(NUM_SRC);
  localparam int VEC_W       = $clog2(NUM_VEC);
  localparam int TICK_CYCLES = TICK_NS / CLK_PERIOD_NS;
  localparam int PRE_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLDOFF} vec_state_e;

  logic [NUM_SRC-1:0]              icr_reg, icr_next;
  logic [NUM_SRC-1:0]              ims_reg, ims_next;
  logic [VEC_W-1:0]                map_reg [NUM_SRC];
  logic [ITR_W-1:0]                itr_reg [NUM_VEC];
  logic [PRE_W-1:0]                pre_reg, pre_next;
  logic                            tick;
  logic [NUM_VEC-1:0][NUM_SRC-1:0] route;
  logic [NUM_VEC-1:0]              pend;
  logic [NUM_VEC-1:0]              ack_take;

  // Shared ITR time base; every vector counts the same ticks.
  assign tick     = (pre_reg == PRE_W'(TICK_CYCLES - 1));
  assign pre_next = tick ? '0 : pre_reg + PRE_W'(1);

`ifdef INTR_AUTOCLR_EN
  logic [NUM_SRC-1:0] autoclr_mask;

  always_comb begin
    autoclr_mask = '0;
    for (int v = 0; v < NUM_VEC; v++) begin
      if (ack_take[v]) begin
        autoclr_mask = autoclr_mask | route[v];
      end
    end
  end
`endif

  always_comb begin
    icr_next = icr_reg;
    if (bus.icr_get_i) begin
      icr_next = '0;
    end else if (bus.icr_clr_i) begin
      icr_next = icr_reg & ~bus.reg_wdata_i;
    end else if (bus.ics_set_i) begin
      icr_next = icr_reg | bus.reg_wdata_i;
    end
`ifdef INTR_AUTOCLR_EN
    icr_next = icr_next & ~autoclr_mask;
`endif
    // A cause arriving alongside any clear is never lost.
    icr_next = icr_next | bus.src_req_i;
  end

  always_comb begin
    ims_next = ims_reg;
    if (bus.ims_set_i) begin
      ims_next = ims_reg | bus.reg_wdata_i;
    end else if (bus.imc_set_i) begin
      ims_next = ims_reg & ~bus.reg_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      icr_reg <= '0;
      ims_reg <= '0;
      pre_reg <= '0;
    end else begin
      icr_reg <= icr_next;
      ims_reg <= ims_next;
      pre_reg <= pre_next;
    end
  end

  // Map entries reset to round-robin so every cause has a home before software configures it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        map_reg[i] <= VEC_W'(i % NUM_VEC);
      end
      for (int v = 0; v < NUM_VEC; v++) begin
        itr_reg[v] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.ivar_set_i && (bus.ivar_src_i == SRC_W'(i))) begin
          map_reg[i] <= bus.ivar_vec_i;
        end
      end
      for (int v = 0; v < NUM_VEC; v++) begin
        if (bus.itr_set_i && (bus.itr_idx_i == VEC_W'(v))) begin
          itr_reg[v] <= bus.itr_val_i;
        end
      end
    end
  end

  assign bus.icr_o = icr_reg;
  assign bus.ims_o = ims_reg;

  generate
    for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_vec
      vec_state_e       state_reg, state_next;
      logic [ITR_W-1:0] cnt_reg, cnt_next;

      for (genvar gs = 0; gs < NUM_SRC; gs++) begin : g_route
        assign route[gi][gs] = (map_reg[gs] == VEC_W'(gi));
      end

      assign pend[gi]          = |(icr_reg & ims_reg & route[gi]);
      assign ack_take[gi]      = (state_reg == ST_ASSERT) && bus.vec_ack_i[gi];
      assign bus.vec_req_o[gi] = (state_reg == ST_ASSERT);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          ST_IDLE: begin
            if (pend[gi]) begin
              state_next = ST_ASSERT;
            end
          end
          ST_ASSERT: begin
            // Ack outranks a same-cycle pend drop, so the holdoff still applies.
            if (ack_take[gi]) begin
              if (itr_reg[gi] == '0) begin
                state_next = ST_IDLE;
              end else begin
                state_next = ST_HOLDOFF;
                cnt_next   = itr_reg[gi];
              end
            end else if (!pend[gi]) begin
              state_next = ST_IDLE;
            end
          end
          ST_HOLDOFF: begin
            if (cnt_reg == '0) begin
              state_next = ST_IDLE;
            end else if (tick) begin
              cnt_next = cnt_reg - ITR_W'(1);
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end
  endgenerate
endmodule

// File: tb/tb_intr_vec_ctrl.sv
// Scoreboard bench for intr_vec_ctrl: stimulus pushes expected reads and req edges; a negedge monitor pops and compares.
module tb_intr_vec_ctrl;
  localparam int NUM_SRC = 32;
  localparam int NUM_VEC = 4;
  localparam int ITR_W   = 16;

  logic clk    = 1'b0;
  logic rst_ni = 1'b1;
  always #4 clk = ~clk;

  intr_vec_ctrl_if #(.NUM_SRC(NUM_SRC), .NUM_VEC(NUM_VEC), .ITR_W(ITR_W)) bus ();

  intr_vec_ctrl #(
    .NUM_SRC(NUM_SRC), .NUM_VEC(NUM_VEC), .ITR_W(ITR_W),
    .CLK_PERIOD_NS(8), .TICK_NS(256)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  typedef struct { string name; logic [3:0] val; int lo; int hi; } req_exp_t;
  typedef struct { string name; logic [31:0] icr; logic [31:0] ims; logic [3:0] req; } rd_exp_t;

  req_exp_t   req_q[$];
  rd_exp_t    rd_q[$];
  int         cyc      = 0;
  int         n_vec    = 0;
  int         n_miss   = 0;
  logic       rd_valid = 1'b0;
  logic [3:0] prev_req = 4'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle_in();
    bus.src_req_i   = '0;
    bus.reg_wdata_i = '0;
    bus.icr_get_i   = 1'b0;
    bus.icr_clr_i   = 1'b0;
    bus.ics_set_i   = 1'b0;
    bus.ims_set_i   = 1'b0;
    bus.imc_set_i   = 1'b0;
    bus.itr_set_i   = 1'b0;
    bus.itr_idx_i   = '0;
    bus.itr_val_i   = '0;
    bus.ivar_set_i  = 1'b0;
    bus.ivar_src_i  = '0;
    bus.ivar_vec_i  = '0;
    bus.vec_ack_i   = '0;
    rd_valid        = 1'b0;
  endtask

  // Inputs set after step() are captured at the following posedge.
  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic expect_req(input string name, input logic [3:0] val, input int lo, input int hi);
    req_exp_t e;
    e.name = name; e.val = val; e.lo = lo; e.hi = hi;
    req_q.push_back(e);
  endtask

  task automatic rd(input string name, input logic [31:0] icr, input logic [31:0] ims, input logic [3:0] req);
    rd_exp_t r;
    step();
    rd_valid = 1'b1;
    r.name = name; r.icr = icr; r.ims = ims; r.req = req;
    rd_q.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: register reads on rd_valid, and every change of vec_req_o.
  initial begin
    rd_exp_t  r;
    req_exp_t e;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL rd_q: read at cycle %0d with no expectation", cyc);
        end else begin
          r = rd_q.pop_front();
          check({r.name, ".icr"}, bus.icr_o, r.icr);
          check({r.name, ".ims"}, bus.ims_o, r.ims);
          check({r.name, ".req"}, {28'b0, bus.vec_req_o}, {28'b0, r.req});
        end
      end
      if (bus.vec_req_o !== prev_req) begin
        if (req_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL req_edge: unexpected vec_req_o 0x%0h at cycle %0d, want 0x%0h", bus.vec_req_o, cyc, prev_req);
        end else begin
          e = req_q.pop_front();
          check({e.name, ".val"}, {28'b0, bus.vec_req_o}, {28'b0, e.val});
          n_vec++;
          if (cyc < e.lo || cyc > e.hi) begin
            n_miss++;
            $display("FAIL %s.when: cycle %0d, want %0d..%0d", e.name, cyc, e.lo, e.hi);
          end else begin
            $display("ok   %s.when: cycle %0d in %0d..%0d", e.name, cyc, e.lo, e.hi);
          end
        end
        prev_req = bus.vec_req_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int k;
    idle_in();
    #1 rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_ni = 1'b1;

    // 1: basic cause -> request -> ack
    rd("t1.reset", 32'h0, 32'h0, 4'b0000);
    step(); bus.ims_set_i = 1'b1; bus.reg_wdata_i = 32'h1;
    step(); bus.src_req_i = 32'h1; expect_req("t1.rise", 4'b0001, cyc + 2, cyc + 2);
    rd("t1.icr", 32'h1, 32'h1, 4'b0000);
    step(); bus.vec_ack_i = 4'b0001; bus.icr_clr_i = 1'b1; bus.reg_wdata_i = 32'h1;
    expect_req("t1.ack", 4'b0000, cyc + 1, cyc + 1);
    rd("t1.done", 32'h0, 32'h1, 4'b0000);

    // 2: ITR[0]=3, cause persists; rewriting ITR mid-holdoff must not shorten it
    step(); bus.itr_set_i = 1'b1; bus.itr_idx_i = 2'd0; bus.itr_val_i = 16'd3;
    step(); bus.src_req_i = 32'h1; expect_req("t2.rise", 4'b0001, cyc + 2, cyc + 2);
    step(); step();
    bus.vec_ack_i = 4'b0001;
    t0 = cyc + 1;
    expect_req("t2.holdoff", 4'b0000, t0, t0);
    expect_req("t2.rearm", 4'b0001, t0 + 64, t0 + 100);
    repeat (5) step();
    bus.itr_set_i = 1'b1; bus.itr_idx_i = 2'd0; bus.itr_val_i = 16'd0;
    k = 0;
    while (bus.vec_req_o[0] !== 1'b1 && k < 150) begin
      step();
      k++;
    end
    if (k >= 150) begin
      n_vec++; n_miss++;
      $display("FAIL t2.wait: vec_req_o[0] still 0 after %0d cycles, want 1", k);
    end
    bus.vec_ack_i = 4'b0001; bus.icr_clr_i = 1'b1; bus.reg_wdata_i = 32'h1;
    expect_req("t2.ack", 4'b0000, cyc + 1, cyc + 1);
    rd("t2.done", 32'h0, 32'h1, 4'b0000);

    // 3: cause 5 -> vec 2; mask drop before ack gives no holdoff
    step(); bus.itr_set_i = 1'b1; bus.itr_idx_i = 2'd2; bus.itr_val_i = 16'd50;
    step(); bus.ivar_set_i = 1'b1; bus.ivar_src_i = 5'd5; bus.ivar_vec_i = 2'd2;
    step(); bus.ims_set_i = 1'b1; bus.reg_wdata_i = 32'h20;
    step(); bus.ics_set_i = 1'b1; bus.reg_wdata_i = 32'h20;
    expect_req("t3.rise", 4'b0100, cyc + 2, cyc + 2);
    rd("t3.icr", 32'h20, 32'h21, 4'b0000);
    step(); bus.imc_set_i = 1'b1; bus.reg_wdata_i = 32'h20;
    expect_req("t3.drop", 4'b0000, cyc + 2, cyc + 2);
    step(); step(); bus.ims_set_i = 1'b1; bus.reg_wdata_i = 32'h20;
    expect_req("t3.back", 4'b0100, cyc + 2, cyc + 2);
    step(); step(); bus.vec_ack_i = 4'b0100; bus.icr_clr_i = 1'b1; bus.reg_wdata_i = 32'h20;
    expect_req("t3.ack", 4'b0000, cyc + 1, cyc + 1);
    rd("t3.done", 32'h0, 32'h21, 4'b0000);

    // 4: register priorities
    step(); bus.imc_set_i = 1'b1; bus.reg_wdata_i = 32'h21;
    step(); bus.ics_set_i = 1'b1; bus.reg_wdata_i = 32'h11;
    rd("t4.pre", 32'h11, 32'h0, 4'b0000);
    step(); bus.icr_get_i = 1'b1; bus.src_req_i = 32'h08;
    rd("t4.get", 32'h08, 32'h0, 4'b0000);
    step(); bus.icr_clr_i = 1'b1; bus.ics_set_i = 1'b1; bus.reg_wdata_i = 32'h08;
    rd("t4.clr_over_ics", 32'h0, 32'h0, 4'b0000);
    step(); bus.ims_set_i = 1'b1; bus.imc_set_i = 1'b1; bus.reg_wdata_i = 32'h06;
    rd("t4.ims_over_imc", 32'h0, 32'h06, 4'b0000);
    step(); bus.icr_clr_i = 1'b1; bus.reg_wdata_i = 32'h1; bus.src_req_i = 32'h1;
    rd("t4.src_survives", 32'h1, 32'h06, 4'b0000);
    step(); bus.imc_set_i = 1'b1; bus.reg_wdata_i = 32'h06; bus.icr_get_i = 1'b1;
    rd("t4.end", 32'h0, 32'h0, 4'b0000);

    // 5: causes 0,4 on vec 0 and cause 1 on vec 1; ack vec 0 only
    step(); bus.ims_set_i = 1'b1; bus.reg_wdata_i = 32'h13;
    step(); bus.ics_set_i = 1'b1; bus.reg_wdata_i = 32'h13;
    expect_req("t5.rise", 4'b0011, cyc + 2, cyc + 2);
    step(); step(); bus.vec_ack_i = 4'b0001;
    expect_req("t5.ack0", 4'b0010, cyc + 1, cyc + 1);
`ifdef INTR_AUTOCLR_EN
    rd("t5.icr", 32'h02, 32'h13, 4'b0010);
`else
    expect_req("t5.rereq", 4'b0011, cyc + 2, cyc + 2);
    rd("t5.icr", 32'h13, 32'h13, 4'b0010);
`endif
    step(); bus.vec_ack_i = 4'b0011; bus.icr_get_i = 1'b1;
    expect_req("t5.end", 4'b0000, cyc + 1, cyc + 1);
    rd("t5.done", 32'h0, 32'h13, 4'b0000);

    // 6: async reset between clock edges during a long holdoff
    step(); bus.itr_set_i = 1'b1; bus.itr_idx_i = 2'd1; bus.itr_val_i = 16'd100;
    step(); bus.ics_set_i = 1'b1; bus.reg_wdata_i = 32'h02;
    expect_req("t6.rise", 4'b0010, cyc + 2, cyc + 2);
    step(); step(); bus.vec_ack_i = 4'b0010;
    expect_req("t6.hold", 4'b0000, cyc + 1, cyc + 1);
    repeat (10) step();
    rd("t6.in_reset", 32'h0, 32'h0, 4'b0000);
    #2 rst_ni = 1'b0;
    #3 rst_ni = 1'b1;
    rd("t6.post", 32'h0, 32'h0, 4'b0000);
    step(); bus.ims_set_i = 1'b1; bus.reg_wdata_i = 32'h02;
    step(); bus.src_req_i = 32'h02;
    expect_req("t6.rise2", 4'b0010, cyc + 2, cyc + 2);
    step(); step(); bus.vec_ack_i = 4'b0010;
    expect_req("t6.ack_no_hold", 4'b0000, cyc + 1, cyc + 1);
    expect_req("t6.reassert", 4'b0010, cyc + 2, cyc + 2);
    step(); step(); bus.vec_ack_i = 4'b0010; bus.icr_get_i = 1'b1;
    expect_req("t6.end", 4'b0000, cyc + 1, cyc + 1);
    rd("t6.done", 32'h0, 32'h02, 4'b0000);

    repeat (5) step();
    while (req_q.size() != 0) begin
      req_exp_t e;
      e = req_q.pop_front();
      n_vec++; n_miss++;
      $display("FAIL %s: req edge never seen, want 0x%0h in cycles %0d..%0d", e.name, e.val, e.lo, e.hi);
    end
    while (rd_q.size() != 0) begin
      rd_exp_t r;
      r = rd_q.pop_front();
      n_vec++; n_miss++;
      $display("FAIL %s: read never sampled, want icr 0x%0h", r.name, r.icr);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
